adc_pattern_burst_gen: RTL and testbench

//  Parametrised synthetic-ADC burst source feeding the DMA data FIFO path.

---
 rtl/adc_pattern_burst_gen_if.sv | 15 +
 rtl/adc_pattern_burst_gen.sv | 144 ++++++++++++++
 tb/tb_adc_pattern_burst_gen.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/adc_pattern_burst_gen_if.sv
// Stream interface between the synthetic ADC burst source and its consumer.
//   adc_data   : packed lane word, lane k in bits [k*W +: W]
//   data_valid : adc_data carries a word
//   data_ready : consumer takes the word when valid && ready
// master = producer (burst generator), slave = consumer (DMA FIFO side).
interface adc_pattern_burst_gen_if #(
    parameter int C_DATA_WIDTH = 64
);
    logic [C_DATA_WIDTH-1:0] adc_data;
    logic                    data_valid;
    logic                    data_ready;

    modport master (output adc_data, output data_valid, input data_ready);
    modport slave  (input adc_data, input data_valid, output data_ready);
endinterface

// File: rtl/adc_pattern_burst_gen.sv
// Synthetic ADC burst source. Every PERIOD clocks (while ack_en is high) it
// emits a burst of BURST_LEN words over a valid/ready stream; each word packs
// N_CHAN lanes filled with a selectable test pattern.
// Ports:
//   clk_100     : clock, rising edge
//   rst         : asynchronous active-high reset
//   ack_en      : acquisition enable, low = synchronous clear
//   mode        : pattern select (0 tagged, 1 ramp, 2 constant, 3 toggle)
//   stream      : master side of the adc_data/data_valid/data_ready stream
//   frame_cnt   : completed bursts (wraps)
//   overrun_cnt : burst starts skipped because a burst was still running (saturates)
//   busy        : high while a burst is being sent
module adc_pattern_burst_gen #(
    parameter int C_DATA_WIDTH = 64,
    parameter int N_CHAN       = 2,
    parameter int BURST_LEN    = 16,
    parameter int PERIOD       = 64,
    parameter int CNT_WIDTH    = 23,
    parameter int OVR_WIDTH    = 16
) (
    input  logic                  clk_100,
    input  logic                  rst,
    input  logic                  ack_en,
    input  logic [1:0]            mode,
    adc_pattern_burst_gen_if.master stream,
    output logic [CNT_WIDTH-1:0]  frame_cnt,
    output logic [OVR_WIDTH-1:0]  overrun_cnt,
    output logic                  busy
);
    localparam int W   = C_DATA_WIDTH / N_CHAN;
    localparam int PW  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int XW  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    // Frame-count field of the tag is at least wide enough to fill the lane.
    localparam int FCW = (CNT_WIDTH > W - 9) ? CNT_WIDTH : W - 9;
    localparam int TW  = FCW + 9;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                  state_q, state_d;
    logic [PW-1:0]           pcnt;
    logic [XW-1:0]           widx;
    logic [1:0]              mode_q;
    logic [W-1:0]            ramp;
    logic [C_DATA_WIDTH-1:0] data_q;
    logic                    valid_q;

    logic                    pcnt_zero, start, accept, last, load;
    logic [XW-1:0]           sel_widx;
    logic [1:0]              sel_mode;
    logic [C_DATA_WIDTH-1:0] next_word;

    assign pcnt_zero = (pcnt == '0);
    assign accept    = valid_q && stream.data_ready;
    assign last      = (widx == XW'(BURST_LEN - 1));

    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            IDLE:    if (pcnt_zero) begin
                         start   = 1'b1;
                         state_d = SEND;
                     end
            SEND:    if (accept && last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (!ack_en) begin
            state_d = IDLE;
            start   = 1'b0;
        end
    end

    // A new word is loaded at burst start or after a non-final acceptance.
    // At start the word is built from the live mode input so word 0 already
    // uses the pattern being latched on that edge.
    assign load     = start || (accept && !last);
    assign sel_widx = start ? '0 : widx + 1'b1;
    assign sel_mode = start ? mode : mode_q;

    for (genvar k = 0; k < N_CHAN; k++) begin : g_lane
        logic [7:0]   s;
        logic [TW-1:0] tag;
        logic [W-1:0] lane;
        always_comb begin
            s   = 8'(int'(sel_widx) * N_CHAN + k);
            tag = {s, FCW'(frame_cnt), 1'(k % 2)};
            case (sel_mode)
                2'd0:    lane = tag[TW-1 -: W];
                2'd1:    lane = ramp + W'(k);
                2'd2:    lane = {(W/16){16'hA55A}};
                default: lane = sel_widx[0] ? {(W/2){2'b10}} : {(W/2){2'b01}};
            endcase
        end
        assign next_word[k*W +: W] = lane;
    end

    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            pcnt        <= '0;
            widx        <= '0;
            mode_q      <= '0;
            ramp        <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_cnt   <= '0;
            overrun_cnt <= '0;
            busy        <= 1'b0;
        end else if (!ack_en) begin
            // Clear aborts any burst outright; the handshake hold does not apply.
            pcnt        <= '0;
            widx        <= '0;
            ramp        <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_cnt   <= '0;
            overrun_cnt <= '0;
            busy        <= 1'b0;
        end else begin
            // Free-running: back-pressure never stalls the burst schedule.
            pcnt <= (pcnt == PW'(PERIOD - 1)) ? '0 : pcnt + 1'b1;
            busy <= (state_d == SEND);
            if (state_q == SEND && pcnt_zero && overrun_cnt != '1)
                overrun_cnt <= overrun_cnt + 1'b1;
            if (load) begin
                data_q  <= next_word;
                valid_q <= 1'b1;
                widx    <= sel_widx;
                if (start) mode_q <= mode;
                if (sel_mode == 2'd1) ramp <= ramp + W'(N_CHAN);
            end else if (accept && last) begin
                valid_q   <= 1'b0;
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    assign stream.adc_data   = data_q;
    assign stream.data_valid = valid_q;
endmodule

// File: tb/tb_adc_pattern_burst_gen.sv
module tb_adc_pattern_burst_gen;
    logic        clk_100 = 1'b0;
    logic        rst     = 1'b1;
    logic        ack_en  = 1'b0;
    logic [1:0]  mode    = 2'd0;
    logic [22:0] frame_cnt;
    logic [15:0] overrun_cnt;
    logic        busy;

    adc_pattern_burst_gen_if #(.C_DATA_WIDTH(64)) sif ();

    adc_pattern_burst_gen dut (
        .clk_100     (clk_100),
        .rst         (rst),
        .ack_en      (ack_en),
        .mode        (mode),
        .stream      (sif.master),
        .frame_cnt   (frame_cnt),
        .overrun_cnt (overrun_cnt),
        .busy        (busy)
    );

    always #5 clk_100 = ~clk_100;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] cap [0:8][0:15];

    typedef struct {
        int          b;
        int          w;
        logic [63:0] exp;
        string       nm;
    } vec_t;
    vec_t tbl [17];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_100);
        #1;
    endtask

    task automatic wait_valid(input int lim, output int n);
        n = 0;
        while (!sif.data_valid && n < lim) begin
            step();
            n++;
        end
        if (!sif.data_valid) chk("wait_valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_burst(input int b, input logic [1:0] m, input int exp_frame);
        int n;
        mode = m;
        sif.data_ready = 1'b1;
        wait_valid(100, n);
        for (int w = 0; w < 16; w++) begin
            chk("burst_valid", 64'(sif.data_valid), 64'd1);
            cap[b][w] = sif.adc_data;
            step();
        end
        chk("burst_end_valid", 64'(sif.data_valid), 64'd0);
        chk("burst_frame_cnt", 64'(frame_cnt), 64'(exp_frame));
    endtask

    initial begin
        int n, acc, cyc;
        logic r;
        logic [63:0] d, e;

        tbl[0]  = '{0, 0,  64'h01000001_00000000, "tag_w0"};
        tbl[1]  = '{0, 5,  64'h0B000001_0A000000, "tag_w5"};
        tbl[2]  = '{0, 15, 64'h1F000001_1E000000, "tag_w15"};
        tbl[3]  = '{1, 0,  64'h00000001_00000000, "ramp_b1_w0"};
        tbl[4]  = '{1, 15, 64'h0000001F_0000001E, "ramp_b1_w15"};
        tbl[5]  = '{2, 7,  64'hA55AA55A_A55AA55A, "const_w7"};
        tbl[6]  = '{3, 0,  64'h55555555_55555555, "toggle_w0"};
        tbl[7]  = '{3, 1,  64'hAAAAAAAA_AAAAAAAA, "toggle_w1"};
        tbl[8]  = '{3, 14, 64'h55555555_55555555, "toggle_w14"};
        tbl[9]  = '{4, 0,  64'h01000009_00000008, "tag_f4_w0"};
        tbl[10] = '{4, 2,  64'h05000009_04000008, "tag_f4_w2"};
        tbl[11] = '{5, 0,  64'h00000021_00000020, "ramp_cont_w0"};
        tbl[12] = '{6, 0,  64'h00000001_00000000, "ramp_clr_w0"};
        tbl[13] = '{6, 15, 64'h0000001F_0000001E, "ramp_clr_w15"};
        tbl[14] = '{7, 0,  64'h00000021_00000020, "ramp_b2_w0"};
        tbl[15] = '{8, 0,  64'h00000041_00000040, "ramp_b3_w0"};
        tbl[16] = '{8, 15, 64'h0000005F_0000005E, "ramp_b3_w15"};

        sif.data_ready = 1'b0;
        step();
        step();
        chk("rst_valid", 64'(sif.data_valid), 64'd0);
        chk("rst_data", sif.adc_data, 64'd0);
        chk("rst_frame", 64'(frame_cnt), 64'd0);
        chk("rst_overrun", 64'(overrun_cnt), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);

        // First burst: word 0 one clock after the pcnt==0 edge
        rst = 1'b0;
        ack_en = 1'b1;
        mode = 2'd0;
        sif.data_ready = 1'b1;
        step();
        chk("start_valid", 64'(sif.data_valid), 64'd1);
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_word0", sif.adc_data, 64'h01000001_00000000);
        run_burst(0, 2'd0, 1);
        run_burst(1, 2'd1, 2);
        run_burst(2, 2'd2, 3);
        run_burst(3, 2'd3, 4);
        run_burst(4, 2'd0, 5);
        run_burst(5, 2'd1, 6);
        chk("no_overrun", 64'(overrun_cnt), 64'd0);

        ack_en = 1'b0;
        step();
        chk("clr_frame", 64'(frame_cnt), 64'd0);
        chk("clr_valid", 64'(sif.data_valid), 64'd0);
        ack_en = 1'b1;
        run_burst(6, 2'd1, 1);
        run_burst(7, 2'd1, 2);
        run_burst(8, 2'd1, 3);

        for (int i = 0; i < 17; i++)
            chk(tbl[i].nm, cap[tbl[i].b][tbl[i].w], tbl[i].exp);

        // Alternating ready: 32 clocks per burst, data held while not ready
        mode = 2'd3;
        sif.data_ready = 1'b0;
        wait_valid(100, n);
        acc = 0;
        cyc = 0;
        while (acc < 16 && cyc < 64) begin
            r = cyc[0];
            d = sif.adc_data;
            e = acc[0] ? 64'hAAAAAAAA_AAAAAAAA : 64'h55555555_55555555;
            chk("toggle_data", d, e);
            sif.data_ready = r;
            step();
            cyc++;
            if (r) acc++;
            else begin
                chk("hold_valid", 64'(sif.data_valid), 64'd1);
                chk("hold_data", sif.adc_data, d);
            end
        end
        chk("toggle_span", 64'(cyc), 64'd32);
        chk("toggle_end_valid", 64'(sif.data_valid), 64'd0);
        chk("toggle_overrun", 64'(overrun_cnt), 64'd0);
        chk("toggle_frame", 64'(frame_cnt), 64'd4);

        // Long stall: three pcnt==0 instants pass while still sending
        mode = 2'd2;
        sif.data_ready = 1'b0;
        wait_valid(100, n);
        repeat (199) step();
        chk("stall_valid", 64'(sif.data_valid), 64'd1);
        chk("stall_data", sif.adc_data, 64'hA55AA55A_A55AA55A);
        chk("stall_busy", 64'(busy), 64'd1);
        chk("stall_overrun", 64'(overrun_cnt), 64'd3);
        chk("stall_frame", 64'(frame_cnt), 64'd4);
        sif.data_ready = 1'b1;
        repeat (16) step();
        chk("release_valid", 64'(sif.data_valid), 64'd0);
        chk("release_frame", 64'(frame_cnt), 64'd5);
        chk("release_overrun", 64'(overrun_cnt), 64'd3);
        chk("release_busy", 64'(busy), 64'd0);
        n = 0;
        while (!sif.data_valid && n < 100) begin
            step();
            n++;
        end
        chk("next_start_gap", 64'(n), 64'd41);
        repeat (16) step();
        chk("post_stall_frame", 64'(frame_cnt), 64'd6);

        // ack_en dropped while word 5 is presented
        mode = 2'd0;
        wait_valid(100, n);
        repeat (5) step();
        chk("abort_word5", sif.adc_data, 64'h0B00000D_0A00000C);
        ack_en = 1'b0;
        step();
        chk("abort_valid", 64'(sif.data_valid), 64'd0);
        chk("abort_data", sif.adc_data, 64'd0);
        chk("abort_frame", 64'(frame_cnt), 64'd0);
        chk("abort_overrun", 64'(overrun_cnt), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        ack_en = 1'b1;
        step();
        chk("restart_valid", 64'(sif.data_valid), 64'd1);
        chk("restart_word0", sif.adc_data, 64'h01000001_00000000);
        repeat (16) step();
        chk("restart_frame", 64'(frame_cnt), 64'd1);

        // Asynchronous reset in the middle of a toggle burst
        mode = 2'd3;
        wait_valid(100, n);
        chk("tog_even", sif.adc_data, 64'h55555555_55555555);
        step();
        chk("tog_odd", sif.adc_data, 64'hAAAAAAAA_AAAAAAAA);
        step();
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 64'(sif.data_valid), 64'd0);
        chk("arst_data", sif.adc_data, 64'd0);
        chk("arst_frame", 64'(frame_cnt), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_overrun", 64'(overrun_cnt), 64'd0);
        step();
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
